// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command initiator.
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WB_DAT_W        = 32;
    localparam int WB_BE_W         = 4;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage : wb_cmd_master_pkg

// File: rtl/wb_timeout_cnt.sv
// Bus-phase cycle counter; expired_o flags the last permitted bus cycle.
module wb_timeout_cnt
    import wb_cmd_master_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count bus cycles without ACK; cleared when a new bus phase starts.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Counter value k-1 during the k-th bus cycle, so this is the TIMEOUT-th.
    assign expired_o = (cnt_q == LAST);

endmodule : wb_timeout_cnt

// File: rtl/wb_cmd_master.sv
// Single-word Wishbone initiator with a valid/ready command and response port.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int ERRCNT_W = 8
) (
    input  logic                WB_CLK,
    input  logic                WB_RSTn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [WB_BE_W-1:0]  cmd_be,
    input  logic [WB_DAT_W-1:0] cmd_wdat,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_rdat,
    output logic                rsp_err,
    output logic                rsp_we,
    output logic [ADDR_W-1:0]   WBs_ADR,
    output logic                WBs_CYC,
    output logic                WBs_STB,
    output logic                WBs_WE,
    output logic                WBs_RD,
    output logic [WB_BE_W-1:0]  WBs_BYTE_STB,
    output logic [WB_DAT_W-1:0] WBs_WR_DAT,
    input  logic [WB_DAT_W-1:0] WBs_RD_DAT,
    input  logic                WBs_ACK,
    output logic [ERRCNT_W-1:0] err_cnt
);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     adr_q, adr_d;
    logic [WB_BE_W-1:0]    be_q, be_d;
    logic [WB_DAT_W-1:0]   wdat_q, wdat_d;
    logic                  we_q, we_d;
    logic [WB_DAT_W-1:0]   rdat_q, rdat_d;
    logic                  err_q, err_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                  cmd_ready_q;
    logic                  cyc_q;
    logic                  wb_we_q;
    logic                  wb_rd_q;
    logic                  rsp_valid_q;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  tmo_expired;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i     (WB_CLK),
        .rst_ni    (WB_RSTn),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (tmo_expired)
    );

    // Next-state logic: capture, ACK/timeout resolution, response hand-off.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        be_d      = be_q;
        wdat_d    = wdat_q;
        we_d      = we_q;
        rdat_d    = rdat_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    adr_d   = cmd_adr;
                    be_d    = cmd_be;
                    wdat_d  = cmd_wdat;
                    we_d    = cmd_we;
                    cnt_clr = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ACK takes priority over a timeout in the same cycle.
                if (WBs_ACK) begin
                    rdat_d  = we_q ? '0 : WBs_RD_DAT;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_expired) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                    end
                    state_d = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge WB_CLK) begin
        if (!WB_RSTn) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            be_q        <= '0;
            wdat_q      <= '0;
            we_q        <= 1'b0;
            rdat_q      <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            be_q        <= be_d;
            wdat_q      <= wdat_d;
            we_q        <= we_d;
            rdat_q      <= rdat_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            cmd_ready_q <= (state_d == IDLE);
            cyc_q       <= (state_d == BUS);
            wb_we_q     <= (state_d == BUS) && we_d;
            wb_rd_q     <= (state_d == BUS) && !we_d;
            rsp_valid_q <= (state_d == RESP);
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdat     = rdat_q;
    assign rsp_err      = err_q;
    assign rsp_we       = we_q;
    assign WBs_ADR      = adr_q;
    assign WBs_CYC      = cyc_q;
    assign WBs_STB      = cyc_q;
    assign WBs_WE       = wb_we_q;
    assign WBs_RD       = wb_rd_q;
    assign WBs_BYTE_STB = be_q;
    assign WBs_WR_DAT   = wdat_q;
    assign err_cnt      = err_cnt_q;

endmodule : wb_cmd_master

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master (TIMEOUT=8, ERRCNT_W=8).
module tb_wb_cmd_master;

    localparam int ADDR_W   = 17;
    localparam int TIMEOUT  = 8;
    localparam int ERRCNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_adr;
    logic [3:0]        cmd_be;
    logic [31:0]       cmd_wdat;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdat;
    logic              rsp_err;
    logic              rsp_we;
    logic [ADDR_W-1:0] wb_adr;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic              wb_rd;
    logic [3:0]        wb_be;
    logic [31:0]       wb_wdat;
    logic [31:0]       wb_rdat;
    logic              wb_ack;
    logic [ERRCNT_W-1:0] err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .WB_CLK       (clk),
        .WB_RSTn      (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_adr      (cmd_adr),
        .cmd_be       (cmd_be),
        .cmd_wdat     (cmd_wdat),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdat     (rsp_rdat),
        .rsp_err      (rsp_err),
        .rsp_we       (rsp_we),
        .WBs_ADR      (wb_adr),
        .WBs_CYC      (wb_cyc),
        .WBs_STB      (wb_stb),
        .WBs_WE       (wb_we),
        .WBs_RD       (wb_rd),
        .WBs_BYTE_STB (wb_be),
        .WBs_WR_DAT   (wb_wdat),
        .WBs_RD_DAT   (wb_rdat),
        .WBs_ACK      (wb_ack),
        .err_cnt      (err_cnt)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_be = '0;
        cmd_wdat = '0; rsp_ready = 1'b0; wb_rdat = '0; wb_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({wb_cyc, wb_stb, wb_we, wb_rd} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {wb_cyc, wb_stb, wb_we, wb_rd}); end
        checks++; if ({rsp_valid, rsp_err, rsp_we} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 000", {rsp_valid, rsp_err, rsp_we}); end
        checks++; if (rsp_rdat !== 32'h0 || err_cnt !== 8'h0) begin errors++; $display("FAIL reset_rdat_errcnt: got %h/%h expected 0/0", rsp_rdat, err_cnt); end
        checks++; if (wb_adr !== '0 || wb_be !== 4'h0 || wb_wdat !== 32'h0) begin errors++; $display("FAIL reset_bus_regs: got %h/%h/%h expected 0", wb_adr, wb_be, wb_wdat); end
        $display("reset: cmd_ready=%b err_cnt=%0d", cmd_ready, err_cnt);
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 17'h00010; cmd_be = 4'hF; cmd_wdat = 32'hA5A55A5A;
        wb_rdat = 32'hFFFF0000;
        tick();
        cmd_valid = 1'b0; cmd_wdat = 32'h0; cmd_adr = '0;
        for (int c = 0; c < 2; c++) begin
            checks++; if ({wb_cyc, wb_stb, wb_we, wb_rd} !== 4'b1110) begin errors++; $display("FAIL write_strobes_c%0d: got %b expected 1110", c, {wb_cyc, wb_stb, wb_we, wb_rd}); end
            checks++; if (wb_adr !== 17'h00010 || wb_be !== 4'hF || wb_wdat !== 32'hA5A55A5A) begin errors++; $display("FAIL write_bus_data_c%0d: got %h/%h/%h expected 00010/f/a5a55a5a", c, wb_adr, wb_be, wb_wdat); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL write_cmd_ready_c%0d: got %b expected 0", c, cmd_ready); end
            if (c == 1) wb_ack = 1'b1;
            tick();
        end
        wb_ack = 1'b0;
        checks++; if ({wb_cyc, wb_stb, wb_we, wb_rd} !== 4'b0000) begin errors++; $display("FAIL write_resp_strobes: got %b expected 0000", {wb_cyc, wb_stb, wb_we, wb_rd}); end
        checks++; if ({rsp_valid, rsp_err, rsp_we} !== 3'b101 || rsp_rdat !== 32'h0) begin errors++; $display("FAIL write_resp: got v/e/we=%b rdat=%h expected 101 rdat=0", {rsp_valid, rsp_err, rsp_we}, rsp_rdat); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL write_release: got rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready); end
        $display("write: adr=00010 wdat=a5a55a5a err=%b", rsp_err);
    endtask

    task automatic test_read();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00004; cmd_be = 4'hF;
        tick();
        cmd_valid = 1'b0;
        checks++; if ({wb_cyc, wb_we, wb_rd} !== 3'b101 || wb_adr !== 17'h00004) begin errors++; $display("FAIL read_bus: got cyc/we/rd=%b adr=%h expected 101/00004", {wb_cyc, wb_we, wb_rd}, wb_adr); end
        wb_ack = 1'b1; wb_rdat = 32'h12345678;
        tick();
        wb_ack = 1'b0; wb_rdat = 32'h0;
        checks++; if (wb_rd !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL read_one_cycle: got rd=%b rsp_valid=%b expected 0/1", wb_rd, rsp_valid); end
        checks++; if (rsp_rdat !== 32'h12345678 || rsp_err !== 1'b0 || rsp_we !== 1'b0) begin errors++; $display("FAIL read_resp: got rdat=%h err=%b we=%b expected 12345678/0/0", rsp_rdat, rsp_err, rsp_we); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL read_turnaround: got cmd_ready=%b rsp_valid=%b expected 1/0", cmd_ready, rsp_valid); end
        rsp_ready = 1'b0;
        $display("read: adr=00004 rdat=%h err=%b", rsp_rdat, rsp_err);
    endtask

    task automatic test_timeout();
        int n;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00020;
        wb_rdat = 32'hDEADBEEF;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (wb_cyc === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL timeout_strobe_cycles: got %0d expected 8", n); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdat !== 32'h0) begin errors++; $display("FAIL timeout_resp: got v=%b e=%b rdat=%h expected 1/1/0", rsp_valid, rsp_err, rsp_rdat); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL timeout_err_cnt: got %0d expected 1", err_cnt); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        $display("timeout: cycles=%0d err=%b err_cnt=%0d", n, rsp_err, err_cnt);
    endtask

    task automatic test_ack_final();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00030;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL ack_final_still_bus: got cyc=%b expected 1", wb_cyc); end
        wb_ack = 1'b1; wb_rdat = 32'hCAFEF00D;
        tick();
        wb_ack = 1'b0; wb_rdat = 32'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdat !== 32'hCAFEF00D) begin errors++; $display("FAIL ack_final_resp: got v=%b e=%b rdat=%h expected 1/0/cafef00d", rsp_valid, rsp_err, rsp_rdat); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ack_final_err_cnt: got %0d expected 1", err_cnt); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        $display("ack_final: rdat=%h err=%b err_cnt=%0d", rsp_rdat, rsp_err, err_cnt);
    endtask

    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 17'h00044; cmd_be = 4'h3; cmd_wdat = 32'h11112222;
        tick();
        cmd_we = 1'b0; cmd_adr = 17'h00050; cmd_be = 4'hC; cmd_wdat = 32'h99998888;
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            wb_ack = (c == 4); wb_rdat = 32'h55AA55AA;
            checks++; if (cmd_ready !== 1'b0 || wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL bp_no_bus_c%0d: got ready=%b cyc=%b stb=%b expected 0/0/0", c, cmd_ready, wb_cyc, wb_stb); end
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_we !== 1'b1 || rsp_rdat !== 32'h0) begin errors++; $display("FAIL bp_rsp_stable_c%0d: got v=%b e=%b we=%b rdat=%h expected 1/0/1/0", c, rsp_valid, rsp_err, rsp_we, rsp_rdat); end
            tick();
        end
        wb_ack = 1'b0; cmd_valid = 1'b0;
        checks++; if (err_cnt !== 8'd1 || wb_adr !== 17'h00044 || wb_wdat !== 32'h11112222) begin errors++; $display("FAIL bp_regs: got err_cnt=%0d adr=%h wdat=%h expected 1/00044/11112222", err_cnt, wb_adr, wb_wdat); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b v=%b expected 1/0", cmd_ready, rsp_valid); end
        $display("backpressure: held 10 cycles, rsp_we=%b rdat=%h", rsp_we, rsp_rdat);
    endtask

    task automatic test_saturation();
        int n;
        cmd_we = 1'b0; cmd_adr = 17'h00060;
        for (int i = 0; i < 300; i++) begin
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            n = 0;
            while (rsp_valid !== 1'b1 && n < 20) begin
                n++;
                tick();
            end
            if (n >= 20) begin
                checks++; errors++;
                $display("FAIL sat_wait_rsp_%0d: got no rsp_valid expected within 20 cycles", i);
                break;
            end
            rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
            if (i == 252) begin
                checks++; if (err_cnt !== 8'd254) begin errors++; $display("FAIL sat_pre: got %0d expected 254", err_cnt); end
            end
        end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", err_cnt); end
        $display("saturation: 300 timeouts, err_cnt=%0d", err_cnt);
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 17'h1ABCD; cmd_be = 4'h5; cmd_wdat = 32'h87654321;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL rst_mid_in_bus: got cyc=%b expected 1", wb_cyc); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({wb_cyc, wb_stb, wb_we, wb_rd} !== 4'b0000 || wb_adr !== '0 || wb_be !== 4'h0 || wb_wdat !== 32'h0) begin errors++; $display("FAIL rst_mid_bus: got %b adr=%h be=%h wdat=%h expected all 0", {wb_cyc, wb_stb, wb_we, wb_rd}, wb_adr, wb_be, wb_wdat); end
        checks++; if (rsp_valid !== 1'b0 || err_cnt !== 8'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: got v=%b err_cnt=%0d ready=%b expected 0/0/1", rsp_valid, err_cnt, cmd_ready); end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00008;
        tick();
        cmd_valid = 1'b0;
        wb_ack = 1'b1; wb_rdat = 32'h0BADCAFE;
        tick();
        wb_ack = 1'b0; wb_rdat = 32'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdat !== 32'h0BADCAFE || rsp_err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_read: got v=%b rdat=%h e=%b err_cnt=%0d expected 1/0badcafe/0/0", rsp_valid, rsp_rdat, rsp_err, err_cnt); end
        tick();
        rsp_ready = 1'b0;
        $display("reset_mid: post-reset read rdat=%h", rsp_rdat);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_final();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_cmd_master

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone initiator for the FPGA fabric: accepts single-word read/write commands on a valid/ready port and drives the `WBs_*` bus that the fabric IP normally receives from the AHB-to-FPGA bridge. It waits for `WBs_ACK` with a bounded timeout and returns read data or an error on a valid/ready response port. It sits between a fabric-side command source (UART or debug sequencer) and the existing Wishbone client IP, or drives that IP directly in simulation benches.

## Interface
- `ADDR_W`, 17: Wishbone address width.
- `TIMEOUT`, 255: maximum cycles in the bus phase before the transaction aborts; range 1..65535.
- `ERRCNT_W`, 8: width of the saturating error counter.

Ports:
- `WB_CLK` input 1: single clock; all logic is on its rising edge.
- `WB_RSTn` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted on `cmd_valid && cmd_ready`.
- `cmd_we` input 1: 1 = write, 0 = read.
- `cmd_adr` input ADDR_W: word address.
- `cmd_be` input 4: byte enables.
- `cmd_wdat` input 32: write data.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed on `rsp_valid && rsp_ready`.
- `rsp_rdat` output 32: read data; 0 for writes and errors.
- `rsp_err` output 1: transaction timed out.
- `rsp_we` output 1: echo of the command's `cmd_we`.
- `WBs_ADR` output ADDR_W, `WBs_CYC` output 1, `WBs_STB` output 1, `WBs_WE` output 1, `WBs_RD` output 1, `WBs_BYTE_STB` output 4, `WBs_WR_DAT` output 32: Wishbone initiator outputs.
- `WBs_RD_DAT` input 32, `WBs_ACK` input 1: Wishbone client responses.
- `err_cnt` output ERRCNT_W: saturating count of timeouts.

## Operation
- FSM states are `IDLE`, `BUS` and `RESP`. All outputs are registered.
- **IDLE**
  - `cmd_ready` = 1; it is 0 in every other state.
  - On handshake, capture the command into the bus registers and go to `BUS`.
- **BUS**
  - `WBs_CYC` = `WBs_STB` = 1.
  - `WBs_WE` = `cmd_we` and `WBs_RD` = `~cmd_we`.
  - `WBs_ADR`, `WBs_BYTE_STB` and `WBs_WR_DAT` hold the captured values, stable for the whole phase.
  - The timeout counter clears on entry and increments each `BUS` cycle without ACK.
- **ACK sampled in BUS**
  - Capture `WBs_RD_DAT` into `rsp_rdat` (reads only; writes give 0).
  - Set `rsp_err` = 0 and go to `RESP`.
- **Timeout**
  - Triggers when the counter reaches `TIMEOUT - 1` with no ACK, i.e. on the `TIMEOUT`-th BUS cycle.
  - Sets `rsp_rdat` = 0 and `rsp_err` = 1.
  - Increments `err_cnt`, saturating at all-ones.
  - Goes to `RESP`.
- **Simultaneous ACK and timeout:** ACK wins; no error is flagged.
- **RESP**
  - All `WBs_*` strobes are 0; address and data registers may hold their values.
  - `rsp_valid` = 1, and `rsp_*` stay stable until the handshake; then go to `IDLE`.
- `WBs_ACK` is ignored outside `BUS`.
- Inputs on the `cmd_*` port are ignored when `cmd_ready` = 0.

## Timing
- **Reset:** `WB_RSTn` low at an edge forces the following, regardless of state (mid-transaction included):
  - state = `IDLE`;
  - `cmd_ready` = 1 from the first cycle after reset;
  - all `WBs_*` outputs = 0;
  - `rsp_valid` = `rsp_err` = `rsp_we` = 0, `rsp_rdat` = 0;
  - `err_cnt` = 0 and timeout counter = 0.
- **Handshake timing:**
  - Command handshake at edge N: `WBs_CYC`/`WBs_STB` high from cycle N+1.
  - ACK sampled at edge M: strobes low and `rsp_valid` high in cycle M+1.
  - Minimum turnaround, with a same-cycle ACK and `rsp_ready` tied high, is 3 cycles per transaction (`IDLE`, `BUS`, `RESP`).
- **Timeout:** with no ACK, strobes are high for exactly `TIMEOUT` cycles, and `rsp_valid` rises on the next cycle.
- **Back-pressure:** `rsp_ready` low holds `RESP` indefinitely. No new bus cycle is issued and no response is overwritten.

## Structure
- **Package `wb_cmd_master_pkg`:**
  - state enum `{IDLE, BUS, RESP}`;
  - `WB_DAT_W` = 32, `WB_BE_W` = 4;
  - default `TIMEOUT`.
- **Sub-module `wb_timeout_cnt`:**
  - clear/enable inputs and a `expired` output;
  - width is `$clog2(TIMEOUT+1)`.
- The FSM, capture registers and `err_cnt` live in the top module.

## Test plan
- **Single write:** `cmd_we`=1, `adr`=0x00010, `be`=0xF, `wdat`=0xA5A55A5A; the client ACKs after 2 cycles.
  - Expect `WBs_WE`=1 and `WBs_RD`=0 with stable data for 2 cycles.
  - Expect `rsp_valid` with `rsp_err`=0, `rsp_rdat`=0, `rsp_we`=1.
- **Single read:** `adr`=0x00004; the client returns 0x12345678 with a same-cycle ACK.
  - Expect `WBs_RD`=1 for 1 cycle.
  - Expect `rsp_rdat`=0x12345678, `rsp_err`=0, 3-cycle turnaround.
- **Timeout:** `TIMEOUT`=8, no ACK.
  - Expect strobes high for exactly 8 cycles, then `rsp_err`=1, `rsp_rdat`=0, `err_cnt`=1.
  - Run 300 timeouts with `ERRCNT_W`=8 and expect `err_cnt` to saturate at 255.
- **ACK on the final timeout cycle:**
  - Expect `rsp_err`=0, data captured, `err_cnt` unchanged.
- **Back-pressure and stray ACK:**
  - Hold `rsp_ready`=0 for 10 cycles with `cmd_valid` asserted.
  - Expect `cmd_ready`=0, no new `WBs_CYC`, and `rsp_*` stable.
  - A stray `WBs_ACK` pulse in `RESP` changes nothing.
- **Reset mid-operation:** assert `WB_RSTn`=0 during `BUS`.
  - Next cycle: all `WBs_*` = 0, `rsp_valid`=0, `err_cnt`=0, `cmd_ready`=1.
  - A following read completes normally.
